// File: rtl/csa_final_adder_if.sv
// ----------------------------------------------------------------------------
// csa_final_adder_if
// Handshake bundle between a carry-save adder tree and the multi-cycle final
// adder.
//   in_valid / in_ready   : operand handshake (sum_in, carry_in, WIDTH bits)
//   out_valid / out_ready : result handshake (result, WIDTH+2 bits)
//   busy                  : adder is working on or holding a result
// Modports: master = producer/consumer side, slave = the adder itself.
// ----------------------------------------------------------------------------
interface csa_final_adder_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] result;
    logic             busy;

    modport master (
        output in_valid, sum_in, carry_in, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, sum_in, carry_in, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/csa_final_adder.sv
// ----------------------------------------------------------------------------
// csa_final_adder
// Resolves a carry-save pair to binary: result = sum_in + (carry_in << 1).
// CHUNK bits are added per clock with the ripple carry held in a register,
// so the critical path stays CHUNK bits long regardless of WIDTH.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : csa_final_adder_if.slave (operand/result handshakes, busy)
// Optional feature macro: CSA_FINAL_ADDER_ZERO_SKIP_EN -- an operand whose
// carry vector is zero bypasses the ADD phase and completes on acceptance.
// ----------------------------------------------------------------------------
module csa_final_adder #(
    parameter int WIDTH = 6,
    parameter int CHUNK = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csa_final_adder_if.slave      bus
);
    localparam int N  = (WIDTH + 1 + CHUNK - 1) / CHUNK;
    localparam int P  = N * CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [P-1:0]    a_q, a_d;
    logic [P-1:0]    b_q, b_d;
    logic [KW-1:0]   k_q, k_d;
    logic            c_q, c_d;
    logic [P:0]      acc_q, acc_d;
    logic            in_ready_q, out_valid_q, busy_q;

    logic [31:0]     base_s;
    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   chunk_sum_s;
    logic             unused_acc_s;

    // Next-state and datapath: one CHUNK-wide ripple step per ADD cycle.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        k_d         = k_q;
        c_d         = c_q;
        acc_d       = acc_q;
        base_s      = 32'(k_q) * 32'(CHUNK);
        a_chunk_s   = a_q[base_s +: CHUNK];
        b_chunk_s   = b_q[base_s +: CHUNK];
        chunk_sum_s = (CHUNK+1)'(a_chunk_s) + (CHUNK+1)'(b_chunk_s)
                    + (CHUNK+1)'(c_q);
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    // Carry vector has weight 2^(i+1), hence the shift.
                    a_d     = P'(bus.sum_in);
                    b_d     = P'({bus.carry_in, 1'b0});
                    k_d     = '0;
                    c_d     = 1'b0;
                    acc_d   = '0;
                    state_d = ST_ADD;
`ifdef CSA_FINAL_ADDER_ZERO_SKIP_EN
                    if (bus.carry_in == '0) begin
                        acc_d   = (P+1)'(bus.sum_in);
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ADD;
                    end
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                acc_d[base_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
                c_d = chunk_sum_s[CHUNK];
                k_d = k_q + KW'(1);
                if (k_q == KW'(N - 1)) begin
                    // Last chunk: its carry-out is the top result bit.
                    acc_d[P] = chunk_sum_s[CHUNK];
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_ADD;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and status flops; status flops mirror the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            k_q         <= '0;
            c_q         <= 1'b0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            k_q         <= k_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_ADD) || (state_d == ST_DONE);
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.result    = acc_q[WIDTH+1:0];

    // Padding bits above the result range never carry information.
    assign unused_acc_s  = &{1'b0, acc_q};
endmodule

// File: tb/tb_csa_final_adder.sv
// ----------------------------------------------------------------------------
// tb_csa_final_adder
// Self-checking bench: a default instance (WIDTH=6, CHUNK=2) for the directed
// cases plus three WIDTH=8 instances (CHUNK 1, 3, 9) fed identical random
// operands. Expected results come from plain arithmetic s + 2*c, expected
// latencies from ceil((WIDTH+1)/CHUNK).
// ----------------------------------------------------------------------------
module tb_csa_final_adder;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    csa_final_adder_if #(.WIDTH(6)) if_d ();
    csa_final_adder #(.WIDTH(6), .CHUNK(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if_d.slave));

    csa_final_adder_if #(.WIDTH(8)) if_s1 ();
    csa_final_adder_if #(.WIDTH(8)) if_s3 ();
    csa_final_adder_if #(.WIDTH(8)) if_s9 ();
    csa_final_adder #(.WIDTH(8), .CHUNK(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .bus(if_s1.slave));
    csa_final_adder #(.WIDTH(8), .CHUNK(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .bus(if_s3.slave));
    csa_final_adder #(.WIDTH(8), .CHUNK(9)) u_s9 (
        .clk(clk), .rst_n(rst_n), .bus(if_s9.slave));

    logic       sw_valid, sw_oready;
    logic [7:0] sw_sum, sw_carry;
    logic [2:0] sw_ov;
    logic [9:0] sw_res [3];

    assign if_s1.in_valid = sw_valid;  assign if_s3.in_valid = sw_valid;  assign if_s9.in_valid = sw_valid;
    assign if_s1.sum_in   = sw_sum;    assign if_s3.sum_in   = sw_sum;    assign if_s9.sum_in   = sw_sum;
    assign if_s1.carry_in = sw_carry;  assign if_s3.carry_in = sw_carry;  assign if_s9.carry_in = sw_carry;
    assign if_s1.out_ready = sw_oready; assign if_s3.out_ready = sw_oready; assign if_s9.out_ready = sw_oready;
    assign sw_ov     = {if_s9.out_valid, if_s3.out_valid, if_s1.out_valid};
    assign sw_res[0] = if_s1.result;
    assign sw_res[1] = if_s3.result;
    assign sw_res[2] = if_s9.result;

    // Single comparison point: counts every vector, reports miscompares.
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    // Edges after the accepting edge until out_valid, bounded at 20.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!if_d.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Reference latency of the default instance for a given carry vector.
    function automatic int ref_lat(input int width, input int chunk,
                                   input logic [31:0] c);
        int l;
        l = (width + chunk) / chunk;   // ceil((width+1)/chunk)
`ifdef CSA_FINAL_ADDER_ZERO_SKIP_EN
        // Zero-carry operands reach DONE on the accepting edge itself.
        if (c == 32'd0) l = 0;
`endif
        return l;
    endfunction

    // Full transaction on the default instance with result/latency checks.
    task automatic dut_txn(input logic [5:0] s, input logic [5:0] c,
                           input string tag);
        int lat;
        for (int i = 0; i < 20 && !if_d.in_ready; i++) begin
            @(posedge clk); #1;
        end
        check_val({tag, "_ready"}, 32'(if_d.in_ready), 32'd1);
        if_d.in_valid = 1'b1;
        if_d.sum_in   = s;
        if_d.carry_in = c;
        @(posedge clk); #1;
        if_d.in_valid = 1'b0;
        if_d.sum_in   = 6'($urandom);
        if_d.carry_in = 6'($urandom);
        wait_out(lat);
        check_val({tag, "_lat"}, 32'(lat), 32'(ref_lat(6, 2, 32'(c))));
        check_val({tag, "_res"}, 32'(if_d.result), 32'(s) + 32'd2 * 32'(c));
        if_d.out_ready = 1'b1;
        @(posedge clk); #1;
        if_d.out_ready = 1'b0;
        check_val({tag, "_ovlo"}, 32'(if_d.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int lats [3];
        int chv  [3];
        logic [7:0] s8, c8;
        logic       done;

        chv = '{1, 3, 9};
        rst_n = 1'b0;
        if_d.in_valid = 1'b0; if_d.out_ready = 1'b0;
        if_d.sum_in = 6'd0;   if_d.carry_in = 6'd0;
        sw_valid = 1'b0; sw_oready = 1'b0; sw_sum = 8'd0; sw_carry = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(if_d.in_ready), 32'd1);
        check_val("rst_out_valid", 32'(if_d.out_valid), 32'd0);
        check_val("rst_busy", 32'(if_d.busy), 32'd0);
        check_val("rst_result", 32'(if_d.result), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // out_ready while idle must do nothing.
        if_d.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if_d.out_ready = 1'b0;
        check_val("idle_ordy_ov", 32'(if_d.out_valid), 32'd0);
        check_val("idle_ordy_rdy", 32'(if_d.in_ready), 32'd1);

        dut_txn(6'b010101, 6'b001110, "nominal");
        dut_txn(6'b111111, 6'b111111, "maximum");
        dut_txn(6'b101010, 6'b000000, "zero_skip");
        for (int v = 0; v < 20; v++) begin
            dut_txn(6'($urandom), 6'($urandom), "rand6");
        end

        // Backpressure: result held, second operand refused until handshake.
        if_d.in_valid = 1'b1; if_d.sum_in = 6'b010101; if_d.carry_in = 6'b001110;
        @(posedge clk); #1;
        if_d.sum_in = 6'b000001; if_d.carry_in = 6'b000001;
        check_val("bp_busy", 32'(if_d.busy), 32'd1);
        wait_out(lat);
        check_val("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_val("bp_result", 32'(if_d.result), 32'd49);
            check_val("bp_in_ready", 32'(if_d.in_ready), 32'd0);
            check_val("bp_out_valid", 32'(if_d.out_valid), 32'd1);
        end
        if_d.out_ready = 1'b1;
        @(posedge clk); #1;
        if_d.out_ready = 1'b0;
        check_val("bp_hs_ov", 32'(if_d.out_valid), 32'd0);
        check_val("bp_hs_rdy", 32'(if_d.in_ready), 32'd1);
        @(posedge clk); #1;
        if_d.in_valid = 1'b0;
        check_val("bp_next_taken", 32'(if_d.in_ready), 32'd0);
        wait_out(lat);
        check_val("bp_next_lat", 32'(lat), 32'd4);
        check_val("bp_next_res", 32'(if_d.result), 32'd3);
        if_d.out_ready = 1'b1;
        @(posedge clk); #1;
        if_d.out_ready = 1'b0;

        // Reset at the second ADD edge of the nominal case.
        if_d.in_valid = 1'b1; if_d.sum_in = 6'b010101; if_d.carry_in = 6'b001110;
        @(posedge clk); #1;
        if_d.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_ov", 32'(if_d.out_valid), 32'd0);
        check_val("mid_rst_busy", 32'(if_d.busy), 32'd0);
        check_val("mid_rst_rdy", 32'(if_d.in_ready), 32'd1);
        check_val("mid_rst_res", 32'(if_d.result), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_rst_hold_ov", 32'(if_d.out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_ov", 32'(if_d.out_valid), 32'd0);
        dut_txn(6'b000001, 6'b000001, "post_rst");

        // Parameter sweep, WIDTH=8, three chunk sizes in lock-step.
        for (int v = 0; v < 200; v++) begin
            s8 = 8'($urandom);
            c8 = 8'($urandom);
            if (v == 0) c8 = 8'd0;
            if (v == 1) begin s8 = 8'hFF; c8 = 8'hFF; end
            sw_valid = 1'b1; sw_sum = s8; sw_carry = c8;
            @(posedge clk); #1;
            sw_valid = 1'b0; sw_sum = 8'($urandom); sw_carry = 8'($urandom);
            lats = '{-1, -1, -1};
            for (int t = 0; t <= 12; t++) begin
                done = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    if (lats[i] < 0 && sw_ov[i]) lats[i] = t;
                    if (lats[i] < 0) done = 1'b0;
                end
                if (done) break;
                @(posedge clk); #1;
            end
            for (int i = 0; i < 3; i++) begin
                check_val($sformatf("sweep_c%0d_lat", chv[i]), 32'(lats[i]),
                          32'(ref_lat(8, chv[i], 32'(c8))));
                check_val($sformatf("sweep_c%0d_res", chv[i]), 32'(sw_res[i]),
                          32'(s8) + 32'd2 * 32'(c8));
            end
            sw_oready = 1'b1;
            @(posedge clk); #1;
            sw_oready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
